// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA frame-buffer slice.
//   - 640x480@60 timing counts (visible, front porch, back porch, retrace,
//     totals) for both axes, as produced by the sync stage.
//   - Frame-buffer geometry: 160x120 pixels, scaled by 4 on screen.
//   - Swap FSM state enumeration.
//   - fb_index(): linear word index of a frame-buffer pixel, y*160+x.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HB = 48;
  localparam int HR = 96;
  localparam int HT = HD + HF + HB + HR;

  localparam int VD = 480;
  localparam int VF = 10;
  localparam int VB = 33;
  localparam int VR = 2;
  localparam int VT = VD + VF + VB + VR;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE    = 4;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam int FB_AW    = $clog2(FB_WORDS);

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  function automatic logic [FB_AW-1:0] fb_index(input logic [7:0] x,
                                                input logic [6:0] y);
    return FB_AW'(y) * FB_AW'(FB_W) + FB_AW'(x);
  endfunction

endpackage

// File: rtl/vga_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// vga_frame_buffer_if
// Producer-side bus of the frame buffer.
//   wr_valid/wr_ready : pixel write handshake (transfer when both are 1)
//   wr_x, wr_y        : back-buffer column 0..159 / row 0..119
//   wr_rgb            : pixel colour, CD bits
//   swap_req          : one-cycle request to exchange front and back buffers
//   swap_done         : one-cycle pulse when the exchange takes effect
// master = pixel producer, slave = vga_frame_buffer.
// ---------------------------------------------------------------------------
interface vga_frame_buffer_if #(
  parameter int CD = 12
);

  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    wr_x;
  logic [6:0]    wr_y;
  logic [CD-1:0] wr_rgb;
  logic          swap_req;
  logic          swap_done;

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, swap_req,
    input  wr_ready, swap_done
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, swap_req,
    output wr_ready, swap_done
  );

endinterface

// File: rtl/fb_ram.sv
// ---------------------------------------------------------------------------
// fb_ram
// Simple dual-port RAM holding both frame buffers (2 x WORDS words of CD
// bits). Addresses are {buffer_sel, y*160+x}.
//   clk    : clock
//   we     : write enable
//   waddr  : write address {buffer_sel, index}
//   wdata  : write data
//   raddr  : read address {buffer_sel, index}
//   rdata  : registered read data, one clock after raddr
// Contents are never reset.
// ---------------------------------------------------------------------------
module fb_ram
  import vga_pkg::*;
#(
  parameter int CD    = 12,
  parameter int WORDS = FB_WORDS,
  parameter int AW    = FB_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [CD-1:0] wdata,
  input  logic [AW:0]   raddr,
  output logic [CD-1:0] rdata
);

  logic [CD-1:0] mem [2][WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr[AW]][raddr[AW-1:0]];
  end

endmodule

// File: rtl/vga_frame_buffer.sv
// ---------------------------------------------------------------------------
// vga_frame_buffer
// Double-buffered 160x120 frame buffer shown 4x-scaled on a 640x480 display.
// The front buffer (front_sel) is displayed, the back buffer is written by a
// producer; a requested swap takes effect at the start of vertical blank.
//   clk, reset : clock and synchronous active-high reset
//   hc, vc     : current pixel/line count from the sync stage
//   rgb        : pixel colour for the sync stage, 4 clk behind hc/vc
//   wr_bus     : producer bus (pixel writes + swap request/done)
// ---------------------------------------------------------------------------
module vga_frame_buffer
  import vga_pkg::*;
#(
  parameter int CD = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          hc,
  input  logic [10:0]          vc,
  output logic [CD-1:0]        rgb,
  vga_frame_buffer_if.slave    wr_bus
);

  swap_state_t state_q, state_d;
  logic        front_sel;
  logic        vblank_start;
  logic        ready;
  logic        swap_fire;

  logic        wr_fire;
  logic        wr_in_range;
  logic        wr_en;
  logic [FB_AW:0] wr_addr;

  logic [10:0] la_x, la_y;
  logic        s1_valid;
  logic [10:0] s1_x, s1_y;
  logic        s2_vis;
  logic [FB_AW:0] rd_addr;
  logic        s3_vis;
  logic [CD-1:0] rd_data;

  assign vblank_start = (hc == 11'd0) && (vc == 11'(VD));

  // ---------------- swap FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWAP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A request seen while already pending is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SWAP_IDLE:    if (wr_bus.swap_req) state_d = SWAP_PENDING;
      SWAP_PENDING: if (vblank_start)    state_d = SWAP_IDLE;
      default:      state_d = SWAP_IDLE;
    endcase
  end

  // Writes are blocked while a swap is pending so that nothing lands in a
  // buffer that is about to become visible.
  always_comb begin
    ready     = 1'b0;
    swap_fire = 1'b0;
    if (!reset) begin
      ready     = (state_q == SWAP_IDLE);
      swap_fire = (state_q == SWAP_PENDING) && vblank_start;
    end
  end

  assign wr_bus.wr_ready  = ready;
  assign wr_bus.swap_done = swap_fire;

  // Reset abandons a pending swap and returns to buffer 0 as the front.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel <= 1'b0;
    end else if (swap_fire) begin
      front_sel <= ~front_sel;
    end
  end

  // ---------------- write port ----------------
  // Out-of-range writes still complete the handshake but never reach the RAM.
  assign wr_fire     = wr_bus.wr_valid && ready;
  assign wr_in_range = (wr_bus.wr_x < 8'(FB_W)) && (wr_bus.wr_y < 7'(FB_H));
  assign wr_en       = wr_fire && wr_in_range;
  assign wr_addr     = {~front_sel, fb_index(wr_bus.wr_x, wr_bus.wr_y)};

  // ---------------- read pipeline ----------------
  // Look one pixel ahead so that, after the 4-clk pipeline, rgb lines up with
  // the coordinate the sync stage is presenting.
  always_comb begin
    la_x = hc + 11'd1;
    la_y = vc;
    if (hc == 11'(HT - 1)) begin
      la_x = 11'd0;
      la_y = (vc == 11'(VT - 1)) ? 11'd0 : vc + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= 1'b1;
    end
    s1_x <= la_x;
    s1_y <= la_y;
  end

  // Off-screen coordinates read word 0 so the RAM index always stays in range.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vis <= 1'b0;
    end else begin
      s2_vis <= s1_valid && (s1_x < 11'(HD)) && (s1_y < 11'(VD));
    end
    if ((s1_x < 11'(HD)) && (s1_y < 11'(VD))) begin
      rd_addr <= {front_sel, fb_index(s1_x[9:2], s1_y[8:2])};
    end else begin
      rd_addr <= {front_sel, {FB_AW{1'b0}}};
    end
  end

  fb_ram #(
    .CD    (CD),
    .WORDS (FB_WORDS),
    .AW    (FB_AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_bus.wr_rgb),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_vis <= 1'b0;
    end else begin
      s3_vis <= s2_vis;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else begin
      rgb <= s3_vis ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_buffer
// Directed bench for vga_frame_buffer. hc/vc are driven directly (one pixel
// tick = 4 clk), so coordinates can jump to the points of interest.
// ---------------------------------------------------------------------------
module tb_vga_frame_buffer;

  localparam int CD = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   hc;
  logic [10:0]   vc;
  logic [CD-1:0] rgb;

  int total = 0;
  int bad   = 0;

  vga_frame_buffer_if #(.CD(CD)) wr_bus ();

  vga_frame_buffer #(.CD(CD)) dut (
    .clk    (clk),
    .reset  (reset),
    .hc     (hc),
    .vc     (vc),
    .rgb    (rgb),
    .wr_bus (wr_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Hold one coordinate for a full pixel tick.
  task automatic applyStimulus(input int h, input int v);
    hc = 11'(h);
    vc = 11'(v);
    repeat (4) step();
  endtask

  // Present the coordinate preceding (h,v), then (h,v) itself, and check rgb
  // on each of the 4 clk cycles that (h,v) is on hc/vc.
  task automatic show_pixel(input string tag, input int h, input int v,
                            input logic [CD-1:0] exp);
    int ph;
    int pv;
    if (h == 0) begin
      ph = 799;
      pv = (v == 0) ? 524 : v - 1;
    end else begin
      ph = h - 1;
      pv = v;
    end
    applyStimulus(ph, pv);
    hc = 11'(h);
    vc = 11'(v);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput(tag, 32'(rgb), 32'(exp));
      step();
    end
  endtask

  task automatic write_px(input int x, input int y, input logic [CD-1:0] c);
    int n;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_x     = 8'(x);
    wr_bus.wr_y     = 7'(y);
    wr_bus.wr_rgb   = c;
    n = 0;
    @(negedge clk);
    while (!wr_bus.wr_ready && n < 16) begin
      step();
      @(negedge clk);
      n++;
    end
    checkOutput("wr_ready", 32'(wr_bus.wr_ready), 32'd1);
    step();
    wr_bus.wr_valid = 1'b0;
  endtask

  task automatic do_swap(input string tag);
    wr_bus.swap_req = 1'b1;
    step();
    wr_bus.swap_req = 1'b0;
    hc = 11'd0;
    vc = 11'd480;
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(wr_bus.swap_done), 32'd1);
    step();
    @(negedge clk);
    checkOutput({tag, "_clear"}, 32'(wr_bus.swap_done), 32'd0);
    checkOutput({tag, "_ready"}, 32'(wr_bus.wr_ready), 32'd1);
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: bench did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    hc              = 11'd0;
    vc              = 11'd0;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_x     = 8'd0;
    wr_bus.wr_y     = 7'd0;
    wr_bus.wr_rgb   = '0;
    wr_bus.swap_req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_rgb", 32'(rgb), 32'h0);
    checkOutput("rst_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
    checkOutput("rst_swap_done", 32'(wr_bus.swap_done), 32'd0);
    checkOutput("rst_front_sel", 32'(dut.front_sel), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(wr_bus.wr_ready), 32'd1);
    step();

    // Image A into the back buffer
    $display("[TB] writing image A");
    write_px(0, 0, 12'h5A5);
    write_px(3, 2, 12'hF00);
    write_px(2, 2, 12'h000);
    write_px(4, 2, 12'h000);
    write_px(3, 1, 12'h000);
    write_px(0, 2, 12'h00F);
    write_px(159, 119, 12'h0F0);

    // A write offered while reset is asserted must be dropped
    reset           = 1'b1;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_x     = 8'd0;
    wr_bus.wr_y     = 7'd0;
    wr_bus.wr_rgb   = 12'h123;
    step();
    @(negedge clk);
    checkOutput("rst_write_ready", 32'(wr_bus.wr_ready), 32'd0);
    step();
    wr_bus.wr_valid = 1'b0;
    reset           = 1'b0;
    step();

    // Swap requested mid-frame; second request while pending is ignored
    $display("[TB] swap 1");
    hc = 11'd100;
    vc = 11'd200;
    wr_bus.swap_req = 1'b1;
    step();
    wr_bus.swap_req = 1'b0;
    hc = 11'd101;
    @(negedge clk);
    checkOutput("pend_ready_a", 32'(wr_bus.wr_ready), 32'd0);
    checkOutput("pend_done_a", 32'(wr_bus.swap_done), 32'd0);
    step();
    hc = 11'd799;
    vc = 11'd479;
    wr_bus.swap_req = 1'b1;
    @(negedge clk);
    checkOutput("pend_ready_b", 32'(wr_bus.wr_ready), 32'd0);
    step();
    wr_bus.swap_req = 1'b0;
    hc = 11'd0;
    vc = 11'd479;
    @(negedge clk);
    checkOutput("pend_ready_c", 32'(wr_bus.wr_ready), 32'd0);
    checkOutput("pend_done_c", 32'(wr_bus.swap_done), 32'd0);
    step();
    hc = 11'd1;
    vc = 11'd480;
    @(negedge clk);
    checkOutput("pend_done_d", 32'(wr_bus.swap_done), 32'd0);
    step();
    hc = 11'd0;
    vc = 11'd480;
    @(negedge clk);
    checkOutput("swap1_done", 32'(wr_bus.swap_done), 32'd1);
    checkOutput("swap1_ready_low", 32'(wr_bus.wr_ready), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("swap1_single_pulse", 32'(wr_bus.swap_done), 32'd0);
      checkOutput("swap1_ready_high", 32'(wr_bus.wr_ready), 32'd1);
      step();
    end
    checkOutput("swap1_front_sel", 32'(dut.front_sel), 32'd1);

    // Image A on screen
    show_pixel("px_12_8", 12, 8, 12'hF00);
    show_pixel("px_15_11", 15, 11, 12'hF00);
    show_pixel("px_13_10", 13, 10, 12'hF00);
    show_pixel("px_11_8", 11, 8, 12'h000);
    show_pixel("px_16_8", 16, 8, 12'h000);
    show_pixel("px_12_7", 12, 7, 12'h000);
    show_pixel("px_frame_wrap", 0, 0, 12'h5A5);
    show_pixel("px_line_wrap", 0, 8, 12'h00F);
    show_pixel("px_636_476", 636, 476, 12'h0F0);
    show_pixel("px_639_479", 639, 479, 12'h0F0);
    show_pixel("px_off_x", 640, 8, 12'h000);
    show_pixel("px_off_y", 0, 512, 12'h000);

    // Back-buffer writes concurrent with display do not disturb the front
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_x     = 8'd3;
    wr_bus.wr_y     = 7'd2;
    wr_bus.wr_rgb   = 12'h00F;
    show_pixel("front_during_wr", 12, 8, 12'hF00);
    wr_bus.wr_valid = 1'b0;
    write_px(0, 6, 12'h000);
    write_px(160, 5, 12'hFFF);
    write_px(5, 120, 12'hFFF);
    show_pixel("front_after_wr", 13, 9, 12'hF00);

    do_swap("swap2");
    checkOutput("swap2_front_sel", 32'(dut.front_sel), 32'd0);
    show_pixel("b0_px_12_8", 12, 8, 12'h00F);
    show_pixel("b0_oor_discard", 0, 24, 12'h000);

    // Reset while pending abandons the swap
    $display("[TB] reset during pending swap");
    hc = 11'd100;
    vc = 11'd200;
    wr_bus.swap_req = 1'b1;
    step();
    wr_bus.swap_req = 1'b0;
    @(negedge clk);
    checkOutput("rstpend_ready", 32'(wr_bus.wr_ready), 32'd0);
    step();
    reset = 1'b1;
    hc = 11'd0;
    vc = 11'd480;
    @(negedge clk);
    checkOutput("rstpend_done_in_rst", 32'(wr_bus.swap_done), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstpend_done_after", 32'(wr_bus.swap_done), 32'd0);
    checkOutput("rstpend_ready_after", 32'(wr_bus.wr_ready), 32'd1);
    checkOutput("rstpend_front_sel", 32'(dut.front_sel), 32'd0);
    step();
    show_pixel("rstpend_image", 12, 8, 12'h00F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_buffer.md
VGA_FRAME_BUFFER -- requirements
Module: vga_frame_buffer

Interface
REQ-001 Parameter CD, default 12: bits per RGB pixel sample.
REQ-002 clk  input  1  system clock (100 MHz); the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 hc  input  11  current horizontal pixel count from the sync stage, 0..799.
REQ-005 vc  input  11  current vertical line count from the sync stage, 0..524.
REQ-006 rgb  output  CD  pixel colour fed to the sync stage's video stream input.
REQ-007 wr_valid  input  1  producer offers one pixel write.
REQ-008 wr_ready  output  1  block accepts the write this cycle.
REQ-009 wr_x  input  8  back-buffer column, 0..159.
REQ-010 wr_y  input  7  back-buffer row, 0..119.
REQ-011 wr_rgb  input  CD  pixel colour to write.
REQ-012 swap_req  input  1  single-cycle request to exchange the front and back buffers.
REQ-013 swap_done  output  1  single-cycle pulse when the exchange takes effect.

Function
REQ-014 The block SHALL hold two 160x120xCD buffers: the front buffer is displayed and the back buffer is written; front_sel selects the front buffer.
REQ-015 Display SHALL scale by 4 in both axes: pixel (hc,vc) with hc<640 and vc<480 shows front[vc/4][hc/4].
REQ-016 Read pipeline: coordinate lookahead, address, RAM read, output register; 4 clk from a change on hc/vc to a change on rgb.
REQ-017 Lookahead coordinate SHALL be (hc+1, vc); (799,v) SHALL map to (0,v+1); (799,524) SHALL map to (0,0).
REQ-018 Given the sync stage's 4-clk pixel tick, rgb SHALL present pixel (hc,vc) on exactly the clk cycles during which hc/vc equal that coordinate.
REQ-019 rgb SHALL be 0 for a lookahead coordinate outside 640x480.
REQ-020 Writes SHALL use a valid/ready handshake: a write transfers on a cycle with wr_valid=1 and wr_ready=1; wr_x, wr_y and wr_rgb are held by the producer until the transfer.
REQ-021 A transferred write with wr_x<160 and wr_y<120 SHALL update the back buffer on the next clk edge; an out-of-range write SHALL be accepted and discarded.
REQ-022 Swap FSM states: IDLE and PENDING; wr_ready=1 in IDLE and 0 in PENDING.
REQ-023 IDLE->PENDING on swap_req=1; a write transferring in the same cycle SHALL land in the pre-swap back buffer.
REQ-024 PENDING->IDLE on the cycle where hc==0 and vc==480 (start of vertical blank); on that transition front_sel SHALL toggle and swap_done SHALL pulse for 1 clk.
REQ-025 swap_req while PENDING SHALL be ignored; it is neither queued nor counted.
REQ-026 A display read and a write in the same cycle SHALL proceed independently on separate RAM ports, with no stall or priority.
REQ-027 Buffer contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-028 While reset=1: rgb=0, swap_done=0, wr_ready=0, state=IDLE, front_sel=0, and all pipeline valid bits cleared.
REQ-029 wr_ready SHALL go to 1 on the first cycle after reset deasserts.
REQ-030 Reset asserted while PENDING SHALL abandon the swap without toggling front_sel.
REQ-031 A write handshaking on the same edge that reset is sampled SHALL be dropped.

Structure
REQ-032 Package vga_pkg SHALL hold HD/HF/HB/HR/VD/VF/VB/VR/HT/VT, FB_W=160, FB_H=120, SCALE=4, and the swap-FSM state enumeration.
REQ-033 Sub-module fb_ram SHALL be a simple dual-port RAM (one write port, one registered read port, 1-clk read latency) of 2x19200 words, addressed by {buffer_sel, y*160+x}.

Verification
REQ-034 Reset, write (3,2)=0xF00 and swap, wait for swap_done -> rgb=0xF00 at hc 12..15 on vc 8..11, and rgb=0xF00 exactly while hc=12 and never while hc=11 or 16.
REQ-035 swap_req at hc=100, vc=200 -> wr_ready=0 until hc=0/vc=480, then swap_done pulses once and wr_ready=1 on the next cycle.
REQ-036 Second swap_req while PENDING -> one swap_done only, and front_sel toggles once.
REQ-037 Write to (160,5) and to (5,120) -> both accepted, with no visible pixel change after a swap.
REQ-038 Writes to the back buffer during display -> front-buffer output unchanged until swap; pixel (159,119) shows at hc=636..639, vc=476..479.
REQ-039 Reset asserted while PENDING -> no swap_done, front_sel=0, and the original image is still displayed.
